// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_program_loader
// Brief   : 8N1 UART receiver that pairs bytes into 12-bit instruction-memory
//           writes. Optional macro LOADER_TIMEOUT_EN drops a stale half-word.
// Revision: 1.0 - initial release
// ============================================================================
module uart_program_loader #(
  parameter int         CLKS_PER_BIT = 10416,
  parameter int         DEPTH        = 8,
  parameter int         ADDR_W       = 3,
  parameter logic [3:0] MARKER       = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              frame_err,
  output logic              sync_err
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q;
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic [7:0]          low_q;
  logic                phase_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [11:0]         wr_data_q;
  logic                done_q;
  logic [ADDR_W:0]     count_q;
  logic                frame_err_q;
  logic                sync_err_q;

  logic                start_det;
  logic                timeout;
  logic [ADDR_W:0]     count_d;

  assign start_det = rx_prev_q & ~rx_sync_q;
  assign count_d   = count_q + 1'b1;

`ifdef LOADER_TIMEOUT_EN
  localparam int            TO_LIMIT = 20 * CLKS_PER_BIT;
  localparam int            TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT);

  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (to_cnt_q == TO_LAST) && phase_q && (state_q == S_IDLE);

  // Only counts while a lone first byte waits in an idle receiver.
  always_ff @(posedge clk) begin
    if (rst || start_det || timeout || !phase_q || state_q != S_IDLE) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      low_q       <= '0;
      phase_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      wr_en_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_det && load_en && !done_q) begin
            state_q <= S_START;
            baud_q  <= '0;
          end
        end
        S_START: begin
          if (baud_q == BAUD_HALF) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            state_q   <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
            if (!rx_sync_q) begin
              frame_err_q <= 1'b1;
            end else if (!phase_q) begin
              low_q   <= shift_q;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (shift_q[7:4] != MARKER) begin
                sync_err_q <= 1'b1;
              end else if (!done_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= count_q[ADDR_W-1:0];
                wr_data_q <= {shift_q[3:0], low_q};
                count_q   <= count_d;
                done_q    <= (count_d == DEPTH_C);
              end
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (timeout) begin
        phase_q    <= 1'b0;
        sync_err_q <= 1'b1;
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != S_IDLE) | phase_q;
  assign done      = done_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_program_loader
// Brief   : Directed self-checking bench for uart_program_loader (16 clk/bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          load_en = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          frame_err;
  logic          sync_err;

  int checks = 0;
  int failures = 0;

  int          n_wr = 0;
  logic [AW-1:0] mon_addr [64];
  logic [11:0]   mon_data [64];
  logic [AW:0]   mon_count[64];
  logic          mon_done [64];

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .MARKER      (4'hA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .load_en  (load_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .frame_err(frame_err),
    .sync_err (sync_err)
  );

  // Write log: every cycle with wr_en high is one entry, so a stretched strobe shows up.
  always @(negedge clk) begin
    if (wr_en && n_wr < 64) begin
      mon_addr[n_wr]  = wr_addr;
      mon_data[n_wr]  = wr_data;
      mon_count[n_wr] = count;
      mon_done[n_wr]  = done;
      n_wr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    load_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic send_pair(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo, 1'b1);
    send_byte(hi, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, count, frame_err, sync_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h busy=%b done=%b count=%h ferr=%b serr=%b required all 0",
               wr_en, wr_addr, wr_data, busy, done, count, frame_err, sync_err);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single_pair();
    int n0;
    do_reset();
    n0 = n_wr;
    send_pair(8'h3C, 8'hA5);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1) begin
      failures++; $display("FAIL single_writes: got %0d required 1", n_wr - n0);
    end
    checks++;
    if (mon_addr[n0] !== 3'd0) begin
      failures++; $display("FAIL single_addr: got %h required 0", mon_addr[n0]);
    end
    checks++;
    if (mon_data[n0] !== 12'h53C) begin
      failures++; $display("FAIL single_data: got %h required 53c", mon_data[n0]);
    end
    checks++;
    if (mon_count[n0] !== 4'd1) begin
      failures++; $display("FAIL single_count_at_write: got %0d required 1", mon_count[n0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL single_busy_after: got %b required 0", busy);
    end
  endtask

  task automatic test_full_program();
    int n0;
    int n1;
    logic [3:0]  nib;
    logic [11:0] exp_d;
    do_reset();
    n0 = n_wr;
    for (int i = 0; i < DEPTH; i++) begin
      nib = 4'(i);
      send_pair({4'h0, nib}, {4'hA, nib});
    end
    tick(4);
    checks++;
    if (n_wr - n0 !== DEPTH) begin
      failures++; $display("FAIL full_writes: got %0d required %0d", n_wr - n0, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      nib   = 4'(i);
      exp_d = {nib, 4'h0, nib};
      checks++;
      if (mon_addr[n0+i] !== 3'(i) || mon_data[n0+i] !== exp_d) begin
        failures++;
        $display("FAIL full_word%0d: got addr=%h data=%h required addr=%h data=%h",
                 i, mon_addr[n0+i], mon_data[n0+i], 3'(i), exp_d);
      end
    end
    checks++;
    if (mon_done[n0+6] !== 1'b0) begin
      failures++; $display("FAIL full_done_early: got %b at 7th write required 0", mon_done[n0+6]);
    end
    checks++;
    if (mon_done[n0+7] !== 1'b1 || mon_count[n0+7] !== 4'd8) begin
      failures++; $display("FAIL full_done_at_last: got done=%b count=%0d required 1/8",
                           mon_done[n0+7], mon_count[n0+7]);
    end
    n1 = n_wr;
    send_pair(8'h09, 8'hA9);
    tick(4);
    checks++;
    if (n_wr !== n1 || count !== 4'd8 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL full_ninth_pair: got writes=%0d count=%0d done=%b busy=%b required 0/8/1/0",
                           n_wr - n1, count, done, busy);
    end
  endtask

  task automatic test_sync_err();
    int n0;
    do_reset();
    n0 = n_wr;
    send_pair(8'h3C, 8'h75);
    tick(4);
    checks++;
    if (sync_err !== 1'b1 || n_wr !== n0 || busy !== 1'b0 || count !== 4'd0) begin
      failures++; $display("FAIL sync_bad_marker: got serr=%b writes=%0d busy=%b count=%0d required 1/0/0/0",
                           sync_err, n_wr - n0, busy, count);
    end
    send_pair(8'h11, 8'hA2);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_addr[n0] !== 3'd0 || mon_data[n0] !== 12'h211) begin
      failures++; $display("FAIL sync_recover: got writes=%0d addr=%h data=%h required 1/0/211",
                           n_wr - n0, mon_addr[n0], mon_data[n0]);
    end
  endtask

  task automatic test_frame_err();
    int n0;
    do_reset();
    n0 = n_wr;
    send_byte(8'h55, 1'b0);
    tick(CPB);
    checks++;
    if (frame_err !== 1'b1 || n_wr !== n0 || count !== 4'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL frame_bad_stop: got ferr=%b writes=%0d count=%0d busy=%b required 1/0/0/0",
                           frame_err, n_wr - n0, count, busy);
    end
    send_pair(8'h3C, 8'hA5);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_addr[n0] !== 3'd0 || mon_data[n0] !== 12'h53C) begin
      failures++; $display("FAIL frame_recover: got writes=%0d addr=%h data=%h required 1/0/53c",
                           n_wr - n0, mon_addr[n0], mon_data[n0]);
    end
    // A bad second byte must leave the stored first byte waiting for its partner.
    send_byte(8'h11, 1'b1);
    send_byte(8'hA7, 1'b0);
    tick(CPB);
    checks++;
    if (busy !== 1'b1 || n_wr - n0 !== 1) begin
      failures++; $display("FAIL frame_phase_held: got busy=%b writes=%0d required 1/1", busy, n_wr - n0);
    end
    send_byte(8'hA2, 1'b1);
    tick(4);
    checks++;
    if (n_wr - n0 !== 2 || mon_addr[n0+1] !== 3'd1 || mon_data[n0+1] !== 12'h211) begin
      failures++; $display("FAIL frame_partner: got writes=%0d addr=%h data=%h required 2/1/211",
                           n_wr - n0, mon_addr[n0+1], mon_data[n0+1]);
    end
  endtask

  task automatic test_glitch();
    int n0;
    do_reset();
    n0 = n_wr;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(7);
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || sync_err !== 1'b0) begin
      failures++; $display("FAIL glitch_flags: got busy=%b ferr=%b serr=%b required 0/0/0",
                           busy, frame_err, sync_err);
    end
    send_pair(8'h3C, 8'hA5);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_data[n0] !== 12'h53C) begin
      failures++; $display("FAIL glitch_then_pair: got writes=%0d data=%h required 1/53c",
                           n_wr - n0, mon_data[n0]);
    end
  endtask

  task automatic test_rst_mid_frame();
    int n0;
    do_reset();
    send_pair(8'h3C, 8'hA5);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, count, frame_err, sync_err} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got wr_en=%b addr=%h data=%h busy=%b done=%b count=%h ferr=%b serr=%b required all 0",
               wr_en, wr_addr, wr_data, busy, done, count, frame_err, sync_err);
    end
    rst = 1'b0;
    tick(4);
    n0 = n_wr;
    send_pair(8'h22, 8'hA3);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_addr[n0] !== 3'd0 || mon_data[n0] !== 12'h322 || count !== 4'd1) begin
      failures++; $display("FAIL rst_mid_restart: got writes=%0d addr=%h data=%h count=%0d required 1/0/322/1",
                           n_wr - n0, mon_addr[n0], mon_data[n0], count);
    end
  endtask

  task automatic test_load_disabled();
    int n0;
    do_reset();
    load_en = 1'b0;
    n0 = n_wr;
    send_pair(8'h3C, 8'hA5);
    tick(4);
    checks++;
    if (n_wr !== n0 || busy !== 1'b0 || count !== 4'd0) begin
      failures++; $display("FAIL load_disabled: got writes=%0d busy=%b count=%0d required 0/0/0",
                           n_wr - n0, busy, count);
    end
    load_en = 1'b1;
  endtask

  task automatic test_lone_byte();
    int n0;
    do_reset();
    n0 = n_wr;
    send_byte(8'h3C, 1'b1);
    tick(400);
`ifdef LOADER_TIMEOUT_EN
    checks++;
    if (sync_err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_fires: got serr=%b busy=%b required 1/0", sync_err, busy);
    end
    send_pair(8'h11, 8'hA2);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_addr[n0] !== 3'd0 || mon_data[n0] !== 12'h211) begin
      failures++; $display("FAIL timeout_recover: got writes=%0d addr=%h data=%h required 1/0/211",
                           n_wr - n0, mon_addr[n0], mon_data[n0]);
    end
`else
    checks++;
    if (sync_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL lone_byte_waits: got serr=%b busy=%b required 0/1", sync_err, busy);
    end
    send_byte(8'hA5, 1'b1);
    tick(4);
    checks++;
    if (n_wr - n0 !== 1 || mon_addr[n0] !== 3'd0 || mon_data[n0] !== 12'h53C) begin
      failures++; $display("FAIL lone_byte_partner: got writes=%0d addr=%h data=%h required 1/0/53c",
                           n_wr - n0, mon_addr[n0], mon_data[n0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_full_program();
    test_sync_err();
    test_frame_err();
    test_glitch();
    test_rst_mid_frame();
    test_load_disabled();
    test_lone_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
